// File: rtl/mem_pkg.sv
// Shared store-path definitions: store type codes, RMW FSM states and alignment check.
package mem_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] STORE_SB  = 2'd0;
    localparam logic [1:0] STORE_SH  = 2'd1;
    localparam logic [1:0] STORE_SW  = 2'd2;
    localparam logic [1:0] STORE_RSV = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } rmw_state_t;

    // A store is dropped if its type is reserved or its address is not naturally aligned.
    function automatic logic store_bad(input logic [1:0] typ, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (typ)
            STORE_SH: bad = lane[0];
            STORE_SW: bad = (lane != 2'b00);
            STORE_RSV: bad = 1'b1;
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request handshake from the MEM stage and the single-port data-memory bus.
interface store_rmw_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              done;
    logic              err;

    // Store unit side.
    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, mem_rdata, mem_ack,
        output req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, err
    );

    // Pipeline plus memory side.
    modport master (
        output req_valid, req_type, req_addr, req_wdata, mem_rdata, mem_ack,
        input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, err
    );
endinterface

// File: rtl/store_lane_merge.sv
// Merges a byte/halfword/word store into the old memory word, little-endian lanes.
module store_lane_merge
    import mem_pkg::*;
(
    input  logic [1:0]  typ,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old,
    output logic [31:0] merged_c
);

    // Replace only the lanes covered by the store; untouched lanes keep the old data.
    always_comb begin
        merged_c = old;
        case (typ)
            STORE_SB: begin
                case (lane)
                    2'd0:    merged_c[7:0]   = wdata[7:0];
                    2'd1:    merged_c[15:8]  = wdata[7:0];
                    2'd2:    merged_c[23:16] = wdata[7:0];
                    default: merged_c[31:24] = wdata[7:0];
                endcase
            end
            STORE_SH: begin
                if (lane[1]) merged_c[31:16] = wdata[15:0];
                else         merged_c[15:0]  = wdata[15:0];
            end
            STORE_SW: merged_c = wdata;
            default:  merged_c = old;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Sequential store engine: SW writes directly, SB/SH read-merge-write the enclosing word.
module store_rmw_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    store_rmw_unit_if.slave bus
);

    rmw_state_t  state;
    rmw_state_t  state_n;
    logic [1:0]  lat_type;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;
    logic [31:0] merged_c;
    logic        accept_c;
    logic        bad_c;

    assign accept_c = bus.req_valid && (state == IDLE);
    assign bad_c    = store_bad(bus.req_type, bus.req_addr[1:0]);

    store_lane_merge u_merge (
        .typ      (lat_type),
        .lane     (lat_lane),
        .wdata    (lat_wdata),
        .old      (bus.mem_rdata),
        .merged_c (merged_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; memory acks outside READ/WRITE are ignored.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (bad_c)                          state_n = DONE;
                    else if (bus.req_type == STORE_SW)  state_n = WRITE;
                    else                                state_n = READ;
                end
            end
            READ:    if (bus.mem_ack) state_n = WRITE;
            WRITE:   if (bus.mem_ack) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs decoded from the next state, plus request latch and write-word register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.req_ready <= 1'b1;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            lat_type      <= STORE_SB;
            lat_lane      <= 2'b00;
            lat_wdata     <= '0;
        end else begin
            bus.req_ready <= (state_n == IDLE);
            bus.mem_re    <= (state_n == READ);
            bus.mem_we    <= (state_n == WRITE);
            bus.done      <= (state_n == DONE);
            if (accept_c) begin
                lat_type     <= bus.req_type;
                lat_lane     <= bus.req_addr[1:0];
                lat_wdata    <= bus.req_wdata;
                bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                bus.err      <= bad_c;
                if (bus.req_type == STORE_SW) bus.mem_wdata <= bus.req_wdata;
            end else if (state_n != DONE) begin
                bus.err <= 1'b0;
            end
            if ((state == READ) && bus.mem_ack) bus.mem_wdata <= merged_c;
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed scenarios plus random stores against a word-memory model.
`timescale 1ns/1ps
module tb_store_rmw_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    logic [31:0] mem_model [int unsigned];
    time  last_acc;
    bit   chain_prev;
    int   prev_len;

    store_rmw_unit_if #(.ADDR_W(32)) bus ();

    store_rmw_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        int unsigned key;
        key = addr >> 2;
        if (!mem_model.exists(key)) mem_model[key] = 32'hC0DE0000 ^ key;
        return mem_model[key];
    endfunction

    // Byte-array view of the store: overwrite the covered bytes starting at the byte offset.
    function automatic logic [31:0] apply_store(input logic [1:0] t, input logic [31:0] a,
                                                input logic [31:0] d, input logic [31:0] old);
        logic [7:0]  b [4];
        logic [31:0] res;
        int base, nb;
        base = int'(a % 4);
        nb   = (t == STORE_SB) ? 1 : (t == STORE_SH) ? 2 : 4;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        for (int i = 0; i < nb; i++) b[(base + i) % 4] = d[8*i +: 8];
        for (int i = 0; i < 4; i++) res[8*i +: 8] = b[i];
        return res;
    endfunction

    function automatic bit is_bad(input logic [1:0] t, input logic [31:0] a);
        if (t == 2'd3) return 1'b1;
        if (t == STORE_SH) return (a % 2) != 0;
        if (t == STORE_SW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // Issue one store at a negedge, act as the memory, check the whole transaction timeline.
    task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                            input int rw, input int ww, input bit keep);
        logic [31:0] waddr, old, exp_word;
        bit  bad, fin;
        int  exp_done, done_cyc, k_rd, k_wr, gap;
        time acc_t;
        waddr    = {a[31:2], 2'b00};
        bad      = is_bad(t, a);
        old      = mem_rd(a);
        exp_word = apply_store(t, a, d, old);
        exp_done = bad ? 1 : (t == STORE_SW) ? 2 + ww : 3 + rw + ww;

        chk("ready_before_req", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        acc_t = $time;
        if (chain_prev) begin
            gap = int'((acc_t - last_acc) / 10);
            chk("accept_spacing", gap, prev_len);
        end
        last_acc = acc_t;

        fin = 1'b0; done_cyc = -1; k_rd = 0; k_wr = 0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            if (c == 1 && !keep) bus.req_valid = 1'b0;
            chk("strobe_overlap", bus.mem_re & bus.mem_we, 0);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.mem_re) begin
                chk("rd_addr", bus.mem_addr, waddr);
                if (k_rd == rw) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = old;
                end
                k_rd++;
            end
            if (bus.mem_we) begin
                chk("wr_addr", bus.mem_addr, waddr);
                chk("wr_data", bus.mem_wdata, exp_word);
                if (k_wr == ww) bus.mem_ack = 1'b1;
                k_wr++;
            end
            if (bus.done) begin
                done_cyc = c;
                chk("err_with_done", bus.err, bad);
            end else begin
                chk("err_without_done", bus.err, 0);
            end
            if (bus.req_ready) begin
                fin = 1'b1;
                chk("ready_cycle", c, exp_done + 1);
            end
        end
        bus.mem_ack = 1'b0;
        if (!fin) chk("timeout_waiting_ready", 0, 1);
        chk("done_cycle", done_cyc, exp_done);
        chk("read_cycles", k_rd, (bad || t == STORE_SW) ? 0 : rw + 1);
        chk("write_cycles", k_wr, bad ? 0 : ww + 1);
        if (!bad) mem_model[a >> 2] = exp_word;
        chain_prev = 1'b1;
        prev_len   = exp_done + 1;
    endtask

    initial begin
        logic [1:0]  t;
        logic [31:0] a;
        bus.req_valid = 1'b0;
        bus.req_type  = 2'd0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        chain_prev    = 1'b0;
        prev_len      = 0;
        last_acc      = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_mem_re", bus.mem_re, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios.
        do_store(STORE_SW, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0);
        mem_model[32'h200 >> 2] = 32'h11223344;
        do_store(STORE_SB, 32'h203, 32'h000000AA, 0, 0, 1'b0);
        chk("model_sb_word", mem_model[32'h200 >> 2], 32'hAA223344);
        mem_model[32'h300 >> 2] = 32'h11223344;
        do_store(STORE_SH, 32'h302, 32'h0000BEEF, 2, 2, 1'b0);
        chk("model_sh_word", mem_model[32'h300 >> 2], 32'hBEEF3344);
        do_store(STORE_SH, 32'h401, 32'h12345678, 0, 0, 1'b0);
        do_store(2'd3, 32'h404, 32'h12345678, 0, 0, 1'b0);
        do_store(STORE_SW, 32'h406, 32'h12345678, 0, 0, 1'b0);

        // Valid held high across three SB stores.
        do_store(STORE_SB, 32'h500, 32'h11, 0, 0, 1'b1);
        do_store(STORE_SB, 32'h501, 32'h22, 0, 0, 1'b1);
        do_store(STORE_SB, 32'h502, 32'h33, 0, 0, 1'b0);

        // Reset while READ waits for the memory.
        bus.req_valid = 1'b1;
        bus.req_type  = STORE_SB;
        bus.req_addr  = 32'h504;
        bus.req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        chk("rstmid_in_read", bus.mem_re, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_re", bus.mem_re, 0);
        chk("rstmid_mem_we", bus.mem_we, 0);
        chk("rstmid_ready", bus.req_ready, 1);
        chk("rstmid_done", bus.done, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_no_done", bus.done, 0);
            chk("rstmid_idle_strobes", bus.mem_re | bus.mem_we, 0);
        end
        chain_prev = 1'b0;

        // Random stores over a small region so words get revisited.
        for (int n = 0; n < 60; n++) begin
            t = 2'($urandom_range(0, 3));
            a = 32'h600 + $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) begin
                if (t == STORE_SW) a = {a[31:2], 2'b00};
                if (t == STORE_SH) a = {a[31:1], 1'b0};
            end
            do_store(t, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end
        bus.req_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Sequential store engine between the MEM stage and the single-port data memory. It accepts one store per handshake. For SB/SH it reads the enclosing aligned word, merges the new byte or halfword little-endian, and writes the word back. SW goes straight to a write. While busy it holds `req_ready` low, and the pipeline stalls on that signal.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: store request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid && req_ready`.
- `req_type` in 2: 0=SB, 1=SH, 2=SW, 3=reserved.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, low byte/halfword used for SB/SH.
- `mem_addr` out ADDR_W: word address, `{addr[ADDR_W-1:2],2'b00}`.
- `mem_re` out 1: read strobe.
- `mem_we` out 1: write strobe.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: read data, valid while `mem_ack`=1 in READ.
- `mem_ack` in 1: memory completes current access this cycle.
- `done` out 1: one-cycle pulse, store retired.
- `err` out 1: one-cycle pulse with `done`, store dropped because it was misaligned or reserved.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `req_ready`=1.
  - On accept, latch type, addr and wdata.
  - SB or aligned SH (addr[0]=0): go to READ.
  - SW with addr[1:0]=0: go to WRITE, with `mem_wdata`=wdata.
  - Misaligned SH (addr[0]=1), misaligned SW (addr[1:0]≠0), or type 3: go to DONE with err set. No memory access occurs.
- **READ**
  - `mem_re`=1, `mem_addr`=word address.
  - On `mem_ack`, register the merged word and go to WRITE.
- **Merge rules** (old = `mem_rdata`):
  - SB: replace byte lane addr[1:0] with wdata[7:0].
  - SH addr[1]=0: {old[31:16], wdata[15:0]}.
  - SH addr[1]=1: {wdata[15:0], old[15:0]}.
- **WRITE**
  - `mem_we`=1, `mem_wdata`=registered word.
  - Hold until `mem_ack`, then go to DONE.
- **DONE**
  - `done`=1, `err` as latched, `req_ready`=0.
  - Go to IDLE next cycle.
- `mem_re` and `mem_we` are never both 1.
- `mem_ack` in IDLE/DONE is ignored.
- `mem_addr` and `mem_wdata` are stable for the whole time a strobe is held.
- Reset at any point, including mid-READ/WRITE:
  - Next state is IDLE.
  - Strobes drop at that edge.
  - A pending store is abandoned with no `done`.
  - A partial write never occurs, because the write is a single strobe.
- Reset values: `req_ready`=1 (IDLE), `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `err`=0.

## Timing
- All outputs come from registers or directly from state. There is no combinational path from `req_*` or `mem_*` inputs to outputs.
- Zero-wait memory (`mem_ack` high the same cycle as the strobe), accept edge = cycle 0:
  - SB/SH: READ cycle 1, WRITE cycle 2, `done` cycle 3, `req_ready` again cycle 4.
  - SW: WRITE cycle 1, `done` cycle 2, ready cycle 3.
  - Error case: `done`+`err` cycle 1.
- Each wait cycle (`mem_ack`=0) adds one cycle in the current state.
- Back-to-back requests have a minimum spacing of 3 cycles (SW) or 4 cycles (SB/SH).

## Structure
- Package `mem_pkg` holds:
  - `STORE_SB`/`STORE_SH`/`STORE_SW` 2-bit constants, shared with the MEM-stage decoder.
  - The `rmw_state_t` enum (IDLE/READ/WRITE/DONE).
- Sub-module `store_lane_merge`: combinational inputs (type, addr[1:0], wdata, old word) and output the merged word. Unit-testable on its own.
- The FSM, request latch and output registers live in `store_rmw_unit`.

## Test plan
- Reset, then SW addr 0x100, wdata 0xDEADBEEF, zero-wait: expect `mem_we` cycle 1, addr 0x100, wdata 0xDEADBEEF, `done` cycle 2, `err`=0.
- Memory word 0x11223344; SB addr 0x203, wdata 0xAA: expect read at 0x200, write 0xAA223344, `done` cycle 3.
- Memory 0x11223344; SH addr 0x302, wdata 0xBEEF, `mem_ack` delayed 2 cycles in both READ and WRITE: expect write 0xBEEF3344 and `done` at cycle 7.
- SH addr 0x401, and in a separate request type 3: expect no `mem_re`/`mem_we`, with `done`=`err`=1 at cycle 1.
- SB accepted, `rst` asserted while in READ with `mem_ack`=0: expect strobes low the next cycle, `req_ready`=1, and no `done`.
- `req_valid` held high with 3 SB stores: expect accepts exactly 4 cycles apart, with no overlap of `mem_re`/`mem_we`.
